tetromino_fetch: RTL and testbench
==================================

# tetromino_fetch

- Consumer stage between the game logic core and the tetromino shape ROM (read port 0 of the shape/colour BRAM).
- Accepts a piece-id + rotation request and reads the piece's 32-bit descriptor with a 1-cycle synchronous-read protocol.
- Rotates the 4x4 occupancy mask clockwise one quarter-turn per cycle and returns mask, colour and status on a valid/ready response handshake.
- Keeps BRAM timing and rotation arithmetic out of the game logic core.

## Interface
- `DWIDTH`, 32: BRAM word width.
- `AWIDTH`, 4: BRAM address width; piece id width.
- `MEM_DEPTH`, 10: valid piece ids are 0..MEM_DEPTH-1.
- `clk` input 1: single clock, all logic rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE.
- `req_id` input AWIDTH: piece id (BRAM address).
- `req_rot` input 2: clockwise quarter-turns, 0..3.
- `cache_flush` input 1: invalidates the descriptor cache. Ignored when the cache is compiled out.
- `mem_addr` output AWIDTH: BRAM address.
- `mem_ce` output 1: BRAM enable.
- `mem_we` output 1: tied 0.
- `mem_d` output DWIDTH: tied 0.
- `mem_q` input DWIDTH: BRAM read data, valid on the edge after `mem_ce`.
- `rsp_valid` output 1: response present. Held until `rsp_ready`.
- `rsp_ready` input 1: consumer accepts.
- `rsp_shape` output 16: rotated mask, bit r*4+c = row r, column c.
- `rsp_color` output 8: colour index.
- `rsp_err` output 1: id out of range.
- `rsp_bad_shape` output 1: popcount(mask) != 4.

## Operation
- Descriptor word: [15:0] mask, [23:16] colour, [31:24] reserved (ignored).
- FSM states: IDLE, READ, WAIT, ROT, DONE.
- IDLE:
  - On req_valid && req_ready, latch id and rot.
  - id >= MEM_DEPTH: go to DONE with rsp_err=1, shape 0, colour 0; no BRAM access.
  - Otherwise go to READ.
- READ: drive mem_ce=1, mem_addr=id for exactly one cycle; go to WAIT.
- WAIT: capture mem_q[15:0] and mem_q[23:16]; go to ROT if rot != 0, else DONE.
- ROT: each cycle replace the mask with new[r][c] = old[3-c][r] and decrement the count; go to DONE when the count reaches 0.
- DONE:
  - rsp_valid=1.
  - rsp_bad_shape = (popcount of final mask != 4); popcount is rotation-invariant.
  - On rsp_ready, go to IDLE.
- mem_ce is 0 in every state except READ. mem_addr holds the last id (0 after reset).
- Response fields are stable while rsp_valid=1 and rsp_ready=0.

## Timing
- Reset values: req_ready=0 during reset, 1 in the first IDLE cycle after release. All other outputs are 0. FSM=IDLE, cache invalid.
- Accept at edge E0:
  - mem_ce=1 in the cycle after E0.
  - Data captured at E0+2.
  - rsp_valid first high after edge E0+2+rot.
- Invalid id: rsp_valid high after E0+1.
- Cache hit (macro on): READ/WAIT skipped; rsp_valid high after E0+1+rot.
- Back-to-back: a new request is accepted no earlier than the edge after the response handshake.
- reset asserted mid-operation: immediate return to IDLE. The in-flight response is dropped, mem_ce=0 and rsp_valid=0 asynchronously.
- req_rot is sampled only at accept; later changes are ignored.

## Configuration
- `TETROMINO_CACHE_EN` defined: one-entry cache holding {id, mask, colour, valid}.
  - Filled in WAIT.
  - A request with a matching id and valid=1 bypasses the BRAM.
  - cache_flush clears valid; flush wins over a same-cycle fill.
- `TETROMINO_CACHE_EN` undefined: every in-range request reads the BRAM and cache_flush is unused.

## Structure
- Shared package `tetris_pkg` holds:
  - FSM state enum.
  - Descriptor field constants: SHAPE_LSB=0, SHAPE_W=16, COLOR_LSB=16, COLOR_W=8.
  - Constant CELLS_PER_PIECE=4.
- Sub-module `tetromino_rot90`: purely combinational 16-bit quarter-turn permutation, instantiated once and fed from the mask register.

## Test plan
- BRAM[1]=0x0000_03_00F0, req id=1 rot=0 → rsp_shape=0x00F0, color=0x03, err=0, bad=0, rsp_valid after 2 edges, one mem_ce pulse at addr 1.
- Same word, rot=1 → 0x4444 after 3 edges; rot=2 → 0x0F00 after 4 edges; rot=3 → 0x2222 after 5 edges.
- req id=12 (MEM_DEPTH=10) → rsp_err=1, shape=0, colour=0 after 1 edge, mem_ce never asserted.
- BRAM[2] mask 0x0007 → rsp_bad_shape=1. Hold rsp_ready=0 for 5 cycles → outputs stable and req_ready=0 throughout.
- Cache on: id=3 twice → one mem_ce pulse total, second response after 1+rot edges. Assert cache_flush between them → two pulses.
- Assert reset during ROT → rsp_valid=0 and mem_ce=0 immediately. After release, a request for id=1 rot=0 returns 0x00F0 normally.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and descriptor field layout for the tetromino fetch path.
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_ROT,
    ST_DONE
  } fetch_state_e;

  localparam int unsigned SHAPE_LSB       = 0;
  localparam int unsigned SHAPE_W         = 16;
  localparam int unsigned COLOR_LSB       = 16;
  localparam int unsigned COLOR_W         = 8;
  localparam int unsigned CELLS_PER_PIECE = 4;

  function automatic int unsigned popcount16(input logic [SHAPE_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < SHAPE_W; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/tetromino_rot90.sv
// Clockwise quarter-turn of a 4x4 occupancy mask (bit r*4+c = row r, col c).
module tetromino_rot90
  import tetris_pkg::*;
(
  input  logic [SHAPE_W-1:0] mask_i,
  output logic [SHAPE_W-1:0] mask_o
);

  // new[r][c] = old[3-c][r]
  always_comb begin
    mask_o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        mask_o[r*4 + c] = mask_i[(3 - c)*4 + r];
      end
    end
  end

endmodule

// File: rtl/tetromino_fetch.sv
// Fetches a tetromino descriptor from the shape ROM, rotates its mask and returns it.
// Optional one-entry descriptor cache enabled by defining TETROMINO_CACHE_EN.
module tetromino_fetch
  import tetris_pkg::*;
#(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned AWIDTH    = 4,
  parameter int unsigned MEM_DEPTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_id,
  input  logic [1:0]        req_rot,
  input  logic              cache_flush,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_d,
  input  logic [DWIDTH-1:0] mem_q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_shape,
  output logic [7:0]        rsp_color,
  output logic              rsp_err,
  output logic              rsp_bad_shape
);

  fetch_state_e         state_q, state_d;
  logic [AWIDTH-1:0]    id_q, id_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [SHAPE_W-1:0]   mask_q, mask_d, rot_mask;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 err_q, err_d;
  logic                 bypass_q, bypass_d;
  logic                 req_ready_q, req_ready_d;
  logic                 mem_ce_q, mem_ce_d;
  logic [AWIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 bad_q, bad_d;
  logic                 oor_c, hit_c;
  logic [SHAPE_W-1:0]   hit_mask_c;
  logic [COLOR_W-1:0]   hit_color_c;
  logic                 unused_bits;

  assign oor_c = {1'b0, req_id} >= (AWIDTH+1)'(MEM_DEPTH);

  tetromino_rot90 u_rot90 (
    .mask_i (mask_q),
    .mask_o (rot_mask)
  );

`ifdef TETROMINO_CACHE_EN
  logic [AWIDTH-1:0]  cache_id_q;
  logic [SHAPE_W-1:0] cache_mask_q;
  logic [COLOR_W-1:0] cache_color_q;
  logic               cache_vld_q;

  // Filled from the BRAM word in WAIT; a flush in the same cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_vld_q   <= 1'b0;
      cache_id_q    <= '0;
      cache_mask_q  <= '0;
      cache_color_q <= '0;
    end else if (cache_flush) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == ST_WAIT && !bypass_q) begin
      cache_vld_q   <= 1'b1;
      cache_id_q    <= id_q;
      cache_mask_q  <= mem_q[SHAPE_LSB +: SHAPE_W];
      cache_color_q <= mem_q[COLOR_LSB +: COLOR_W];
    end
  end

  assign hit_c       = cache_vld_q && !cache_flush && (cache_id_q == req_id);
  assign hit_mask_c  = cache_mask_q;
  assign hit_color_c = cache_color_q;
  assign unused_bits = ^mem_q;
`else
  assign hit_c       = 1'b0;
  assign hit_mask_c  = '0;
  assign hit_color_c = '0;
  assign unused_bits = ^{cache_flush, mem_q};
`endif

  // Hit and out-of-range requests pass through WAIT without sampling mem_q,
  // which keeps their response one cycle after accept (plus rotations).
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    color_d  = color_q;
    err_d    = err_q;
    bypass_d = bypass_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          id_d     = req_id;
          cnt_d    = req_rot;
          err_d    = 1'b0;
          bypass_d = 1'b0;
          if (oor_c) begin
            err_d    = 1'b1;
            mask_d   = '0;
            color_d  = '0;
            cnt_d    = 2'd0;
            bypass_d = 1'b1;
            state_d  = ST_WAIT;
          end else if (hit_c) begin
            mask_d   = hit_mask_c;
            color_d  = hit_color_c;
            bypass_d = 1'b1;
            state_d  = ST_WAIT;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!bypass_q) begin
          mask_d  = mem_q[SHAPE_LSB +: SHAPE_W];
          color_d = mem_q[COLOR_LSB +: COLOR_W];
        end
        state_d = (cnt_q != 2'd0) ? ST_ROT : ST_DONE;
      end
      ST_ROT: begin
        mask_d = rot_mask;
        cnt_d  = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    mem_ce_d    = (state_d == ST_READ);
    mem_addr_d  = (state_d == ST_READ) ? id_d : mem_addr_q;
    rsp_valid_d = (state_d == ST_DONE);
    bad_d       = (state_d == ST_DONE) && (popcount16(mask_d) != CELLS_PER_PIECE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      color_q     <= '0;
      err_q       <= 1'b0;
      bypass_q    <= 1'b0;
      req_ready_q <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      color_q     <= color_d;
      err_q       <= err_d;
      bypass_q    <= bypass_d;
      req_ready_q <= req_ready_d;
      mem_ce_q    <= mem_ce_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      bad_q       <= bad_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_ce        = mem_ce_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = 1'b0;
  assign mem_d         = '0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_shape     = mask_q;
  assign rsp_color     = color_q;
  assign rsp_err       = err_q;
  assign rsp_bad_shape = bad_q;

endmodule

// File: tb/tb_tetromino_fetch.sv
// Directed self-checking bench for tetromino_fetch with a 1-cycle BRAM model.
module tb_tetromino_fetch;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

`ifdef TETROMINO_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_id = '0;
  logic [1:0]    req_rot = '0;
  logic          cache_flush = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_ce, mem_we;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [15:0]   rsp_shape;
  logic [7:0]    rsp_color;
  logic          rsp_err, rsp_bad_shape;

  int errors = 0;
  int checks = 0;
  int ce_count = 0;
  logic [AW-1:0] ce_last_addr = '0;
  logic [DW-1:0] mem [16];

  tetromino_fetch #(.DWIDTH(32), .AWIDTH(4), .MEM_DEPTH(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_rot(req_rot), .cache_flush(cache_flush),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we), .mem_d(mem_d),
    .mem_q(mem_q), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_shape(rsp_shape), .rsp_color(rsp_color), .rsp_err(rsp_err),
    .rsp_bad_shape(rsp_bad_shape)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ce) begin
      mem_q <= mem[mem_addr];
      ce_count++;
      ce_last_addr = mem_addr;
    end
  end

  // Issue one request; lat = edges after accept until rsp_valid, -1 on timeout.
  task automatic do_req(input logic [AW-1:0] id, input logic [1:0] rot, output int lat);
    int w;
    lat = -1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (req_ready) begin
      req_valid = 1'b1;
      req_id    = id;
      req_rot   = rot;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_rot   = ~rot;
      if (rsp_valid) lat = 0;
      else begin
        for (int i = 1; i <= 20; i++) begin
          @(posedge clk);
          #1;
          if (rsp_valid) begin
            lat = i;
            break;
          end
        end
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    cache_flush = 1'b1;
    @(negedge clk);
    cache_flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_ce !== 1'b0 || mem_addr !== 4'h0 ||
        rsp_shape !== 16'h0 || rsp_err !== 1'b0 || rsp_bad_shape !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b ce=%0b addr=%0h shape=%h err=%0b bad=%0b required all 0",
               req_ready, rsp_valid, mem_ce, mem_addr, rsp_shape, rsp_err, rsp_bad_shape);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_d !== 32'h0) begin
      errors++;
      $display("FAIL tie_offs: we=%0b d=%h required 0", mem_we, mem_d);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b required 1", req_ready);
    end
  endtask

  task automatic test_rotations();
    logic [15:0] exp_shape [4];
    int lat, ce0;
    exp_shape[0] = 16'h00F0;
    exp_shape[1] = 16'h4444;
    exp_shape[2] = 16'h0F00;
    exp_shape[3] = 16'h2222;
    for (int r = 0; r < 4; r++) begin
      flush_pulse();
      ce0 = ce_count;
      do_req(4'd1, 2'(r), lat);
      checks++;
      if (lat != 2 + r) begin
        errors++;
        $display("FAIL rot%0d_latency: got %0d required %0d", r, lat, 2 + r);
      end
      checks++;
      if (rsp_shape !== exp_shape[r] || rsp_color !== 8'h03 || rsp_err !== 1'b0 || rsp_bad_shape !== 1'b0) begin
        errors++;
        $display("FAIL rot%0d_fields: shape=%h color=%h err=%0b bad=%0b required %h 03 0 0",
                 r, rsp_shape, rsp_color, rsp_err, rsp_bad_shape, exp_shape[r]);
      end
      checks++;
      if (ce_count - ce0 != 1 || ce_last_addr !== 4'd1 || mem_addr !== 4'd1) begin
        errors++;
        $display("FAIL rot%0d_bram: pulses=%0d addr=%0h held=%0h required 1 pulse at 1",
                 r, ce_count - ce0, ce_last_addr, mem_addr);
      end
      handshake();
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rot%0d_handshake: valid=%0b ready=%0b required 0 1", r, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_invalid_id();
    int lat, ce0;
    ce0 = ce_count;
    do_req(4'd12, 2'd2, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL invalid_latency: got %0d required 1", lat);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_shape !== 16'h0 || rsp_color !== 8'h0) begin
      errors++;
      $display("FAIL invalid_fields: err=%0b shape=%h color=%h required 1 0000 00", rsp_err, rsp_shape, rsp_color);
    end
    checks++;
    if (ce_count != ce0) begin
      errors++;
      $display("FAIL invalid_no_bram: pulses=%0d required 0", ce_count - ce0);
    end
    handshake();
  endtask

  task automatic test_bad_shape_hold();
    int lat;
    do_req(4'd2, 2'd0, lat);
    checks++;
    if (lat != 2 || rsp_bad_shape !== 1'b1 || rsp_shape !== 16'h0007 || rsp_color !== 8'h05 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_shape: lat=%0d bad=%0b shape=%h color=%h err=%0b required 2 1 0007 05 0",
               lat, rsp_bad_shape, rsp_shape, rsp_color, rsp_err);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_shape !== 16'h0007 ||
          rsp_color !== 8'h05 || rsp_bad_shape !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%0b ready=%0b shape=%h color=%h bad=%0b required 1 0 0007 05 1",
                 k, rsp_valid, req_ready, rsp_shape, rsp_color, rsp_bad_shape);
      end
    end
    handshake();
  endtask

  task automatic test_cache();
    int lat, ce0;
    ce0 = ce_count;
    do_req(4'd3, 2'd1, lat);
    handshake();
    checks++;
    if (lat != 3 || rsp_shape !== 16'h00CC || ce_count - ce0 != 1) begin
      errors++;
      $display("FAIL cache_first: lat=%0d shape=%h pulses=%0d required 3 00cc 1", lat, rsp_shape, ce_count - ce0);
    end
    ce0 = ce_count;
    do_req(4'd3, 2'd1, lat);
    handshake();
    checks++;
    if (lat != (CACHE_ON ? 2 : 3) || rsp_shape !== 16'h00CC || rsp_color !== 8'h02 ||
        ce_count - ce0 != (CACHE_ON ? 0 : 1)) begin
      errors++;
      $display("FAIL cache_second: lat=%0d shape=%h color=%h pulses=%0d required %0d 00cc 02 %0d",
               lat, rsp_shape, rsp_color, ce_count - ce0, CACHE_ON ? 2 : 3, CACHE_ON ? 0 : 1);
    end
    flush_pulse();
    ce0 = ce_count;
    do_req(4'd3, 2'd1, lat);
    handshake();
    checks++;
    if (lat != 3 || rsp_shape !== 16'h00CC || ce_count - ce0 != 1) begin
      errors++;
      $display("FAIL cache_after_flush: lat=%0d shape=%h pulses=%0d required 3 00cc 1", lat, rsp_shape, ce_count - ce0);
    end
  endtask

  task automatic test_reset_mid();
    int lat, w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1;
    req_id    = 4'd1;
    req_rot   = 2'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (mem_ce !== 1'b1) begin
      errors++;
      $display("FAIL read_ce: got %0b required 1", mem_ce);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_ce !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_read: ce=%0b valid=%0b ready=%0b required 0 0 0", mem_ce, rsp_valid, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    do_req(4'd1, 2'd3, lat);
    checks++;
    if (lat != 5 || rsp_valid !== 1'b1 || rsp_shape !== 16'h2222) begin
      errors++;
      $display("FAIL pre_reset_done: lat=%0d valid=%0b shape=%h required 5 1 2222", lat, rsp_valid, rsp_shape);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || mem_ce !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_done: valid=%0b ce=%0b required 0 0", rsp_valid, mem_ce);
    end
    @(negedge clk);
    reset = 1'b0;
    do_req(4'd1, 2'd0, lat);
    checks++;
    if (lat != 2 || rsp_shape !== 16'h00F0 || rsp_color !== 8'h03) begin
      errors++;
      $display("FAIL after_reset_req: lat=%0d shape=%h color=%h required 2 00f0 03", lat, rsp_shape, rsp_color);
    end
    handshake();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hAA00_0000 | 32'(i);
    mem[1] = 32'h0000_03F0 << 0;
    mem[1] = 32'h0003_00F0;
    mem[2] = 32'hFF05_0007;
    mem[3] = 32'h0002_0033;
    test_reset();
    test_rotations();
    test_invalid_id();
    test_bad_shape_hold();
    test_cache();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
